// File: rtl/sif_pkg.sv
// rtl/sif_pkg.sv - shared types and constants for the SIF responder
//
// Purpose: write record carried through the forward FIFO, W-side FSM state
// encoding, bus widths and the address range helper.
// Ports: none (package).

package sif_pkg;

  localparam int SIF_DW = 16;
  localparam int SIF_AW = 16;

  typedef struct packed {
    logic [SIF_AW-1:0] addr;
    logic [SIF_DW-1:0] data;
  } sif_wr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sif_wstate_e;

  // An address lands in the local register file only when every bit above
  // the register index is zero; with aw == SIF_AW everything is in range.
  function automatic logic addr_in_range(input logic [SIF_AW-1:0] addr, input int aw);
    return ((addr >> aw) == '0);
  endfunction

endpackage

// File: rtl/sif_wr_fifo.sv
// rtl/sif_wr_fifo.sv - synchronous show-ahead FIFO of SIF write records
//
// Purpose: holds accepted X writes until the W-side FSM forwards them.
// Ports:
//   clk    in   clock, posedge
//   rst    in   synchronous reset, active-high; flushes the queue
//   push   in   write din this cycle (ignored when full unless popping too)
//   pop    in   consume the head entry (ignored when empty)
//   din    in   record to enqueue
//   dout   out  head record, valid whenever empty is low
//   full   out  all DEPTH entries occupied
//   empty  out  no entries

module sif_wr_fifo
  import sif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  sif_wr_t din,
  output sif_wr_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit: equal indices with differing wrap bits means full.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  sif_wr_t     mem [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/sif_responder.sv
// rtl/sif_responder.sv - SIF target responder with rate-limited W-side forwarding
//
// Purpose: serves X-side register reads/writes from a local register file and
// forwards every accepted X write, in order, as a W-side write pulse with at
// least W_GAP idle cycles between pulses.
// Ports:
//   clk         in   1   clock, posedge
//   rst         in   1   synchronous reset, active-high
//   xa_wr_s     in   1   X write strobe
//   xa_rd_s     in   1   X read strobe
//   xa_addr     in  16   X address
//   xa_data_wr  in  16   X write data
//   xa_data_rd  out 16   X read data, registered, held until next read
//   wa_wr_s     out  1   W write pulse
//   wa_addr     out 16   W address, held between pulses
//   wa_data_wr  out 16   W write data, held between pulses
//   wr_pending  out  1   queue non-empty or W issue/gap in progress
//   ovf_cnt     out  8   dropped forward count, saturating

module sif_responder
  import sif_pkg::*;
#(
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int W_GAP      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xa_wr_s,
  input  logic        xa_rd_s,
  input  logic [15:0] xa_addr,
  input  logic [15:0] xa_data_wr,
  output logic [15:0] xa_data_rd,
  output logic        wa_wr_s,
  output logic [15:0] wa_addr,
  output logic [15:0] wa_data_wr,
  output logic        wr_pending,
  output logic [7:0]  ovf_cnt
);

  localparam int NREG = 2 ** AW;

  logic [SIF_DW-1:0] regs [NREG];
  logic              in_range;

  sif_wr_t     fifo_din;
  sif_wr_t     fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  sif_wstate_e state;
  sif_wstate_e state_nx;
  logic [3:0]  gap_cnt;
  logic [3:0]  gap_cnt_nx;

  assign in_range = addr_in_range(xa_addr, AW);

  // Register file. A read in the same cycle as a write to the same address
  // sees the old contents because both use non-blocking updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (xa_wr_s && in_range) begin
      regs[xa_addr[AW-1:0]] <= xa_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xa_data_rd <= '0;
    end else if (xa_rd_s) begin
      xa_data_rd <= in_range ? regs[xa_addr[AW-1:0]] : '0;
    end
  end

  // Every write is forwarded, including out-of-range ones.
  assign fifo_din.addr = xa_addr;
  assign fifo_din.data = xa_data_wr;

  sif_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xa_wr_s),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push is lost only when full and not relieved by a pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (xa_wr_s && fifo_full && !fifo_pop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  // Each pop loads the W address/data registers; the pulse follows in ISSUE.
  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (W_GAP > 0) begin
          state_nx   = GAP;
          gap_cnt_nx = 4'(W_GAP);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        gap_cnt_nx = gap_cnt - 4'd1;
        if (gap_cnt == 4'd1) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_nx = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx   = IDLE;
        gap_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wa_addr    <= '0;
      wa_data_wr <= '0;
    end else if (fifo_pop) begin
      wa_addr    <= fifo_dout.addr;
      wa_data_wr <= fifo_dout.data;
    end
  end

  assign wa_wr_s    = (state == ISSUE);
  assign wr_pending = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_sif_responder.sv
// tb/tb_sif_responder.sv - directed self-checking bench for sif_responder

module tb_sif_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_s  [3];
  logic        rd_s  [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ws    [3];
  logic [15:0] waddr [3];
  logic [15:0] wdat  [3];
  logic        pend  [3];
  logic [7:0]  ovf   [3];

  sif_responder #(.AW(4), .FIFO_DEPTH(4), .W_GAP(1)) u0 (
    .clk(clk), .rst(rst), .xa_wr_s(wr_s[0]), .xa_rd_s(rd_s[0]), .xa_addr(addr[0]),
    .xa_data_wr(wdata[0]), .xa_data_rd(rdata[0]), .wa_wr_s(ws[0]), .wa_addr(waddr[0]),
    .wa_data_wr(wdat[0]), .wr_pending(pend[0]), .ovf_cnt(ovf[0]));

  sif_responder #(.AW(4), .FIFO_DEPTH(2), .W_GAP(3)) u1 (
    .clk(clk), .rst(rst), .xa_wr_s(wr_s[1]), .xa_rd_s(rd_s[1]), .xa_addr(addr[1]),
    .xa_data_wr(wdata[1]), .xa_data_rd(rdata[1]), .wa_wr_s(ws[1]), .wa_addr(waddr[1]),
    .wa_data_wr(wdat[1]), .wr_pending(pend[1]), .ovf_cnt(ovf[1]));

  sif_responder #(.AW(4), .FIFO_DEPTH(4), .W_GAP(15)) u2 (
    .clk(clk), .rst(rst), .xa_wr_s(wr_s[2]), .xa_rd_s(rd_s[2]), .xa_addr(addr[2]),
    .xa_data_wr(wdata[2]), .xa_data_rd(rdata[2]), .wa_wr_s(ws[2]), .wa_addr(waddr[2]),
    .wa_data_wr(wdat[2]), .wr_pending(pend[2]), .ovf_cnt(ovf[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // W pulse log per instance: {cycle, addr, data}
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];

  always @(negedge clk) begin
    if (ws[0]) q0.push_back({32'(cyc), waddr[0], wdat[0]});
    if (ws[1]) q1.push_back({32'(cyc), waddr[1], wdat[1]});
    if (ws[2]) q2.push_back({32'(cyc), waddr[2], wdat[2]});
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int           t0;
  logic [63:0]  item;
  logic [31:0]  expq [$];
  logic [31:0]  e;
  int           occ;
  logic         pop_now;
  int           exp_cyc [4];
  int           exp_idx [4];

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_s[k] = 1'b0; rd_s[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    ticks(3);
    rst = 1'b0;

    // reset state
    check("rst_rdata", 32'(rdata[0]), 32'h0);
    check("rst_wa_wr_s", 32'(ws[0]), 32'h0);
    check("rst_wa_addr", 32'(waddr[0]), 32'h0);
    check("rst_pending", 32'(pend[0]), 32'h0);
    check("rst_ovf", 32'(ovf[0]), 32'h0);
    tick();

    // 1: write then read, minimum forward latency
    tick(); wr_s[0] = 1'b1; addr[0] = 16'h0003; wdata[0] = 16'hA5A5;
    tick(); wr_s[0] = 1'b0;
    check("t1_no_pulse_c1", 32'(ws[0]), 32'h0);
    tick(); rd_s[0] = 1'b1; addr[0] = 16'h0003;
    check("t1_pulse_c2", 32'(ws[0]), 32'h1);
    check("t1_wa_addr", 32'(waddr[0]), 32'h0003);
    check("t1_wa_data", 32'(wdat[0]), 32'hA5A5);
    tick(); rd_s[0] = 1'b0;
    check("t1_rdata_c3", 32'(rdata[0]), 32'hA5A5);
    check("t1_pulse_one_cycle", 32'(ws[0]), 32'h0);
    check("t1_wa_addr_hold", 32'(waddr[0]), 32'h0003);
    ticks(4);
    check("t1_pending_clear", 32'(pend[0]), 32'h0);

    // 3: out-of-range write is forwarded, not stored, no aliasing onto reg 0
    tick(); wr_s[0] = 1'b1; addr[0] = 16'h0000; wdata[0] = 16'h5A5A;
    tick(); wr_s[0] = 1'b0;
    ticks(4);
    tick(); wr_s[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'h1234;
    tick(); wr_s[0] = 1'b0;
    tick(); rd_s[0] = 1'b1; addr[0] = 16'h0010;
    check("t3_pulse", 32'(ws[0]), 32'h1);
    check("t3_wa_addr", 32'(waddr[0]), 32'h0010);
    check("t3_wa_data", 32'(wdat[0]), 32'h1234);
    tick(); addr[0] = 16'h0000;
    check("t3_rd_oor", 32'(rdata[0]), 32'h0000);
    tick(); rd_s[0] = 1'b0;
    check("t3_reg0_unchanged", 32'(rdata[0]), 32'h5A5A);
    ticks(4);

    // 4: simultaneous write and read of the same address
    tick(); wr_s[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'h1111;
    tick(); wr_s[0] = 1'b0;
    tick(); wr_s[0] = 1'b1; rd_s[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'h2222;
    tick(); wr_s[0] = 1'b0; rd_s[0] = 1'b0;
    check("t4_rd_old", 32'(rdata[0]), 32'h1111);
    tick();
    check("t4_rd_hold", 32'(rdata[0]), 32'h1111);
    rd_s[0] = 1'b1;
    tick(); rd_s[0] = 1'b0;
    check("t4_rd_new", 32'(rdata[0]), 32'h2222);
    ticks(8);

    // 5: reset while writes are queued and the FSM is in GAP
    tick(); wr_s[0] = 1'b1; addr[0] = 16'h0007; wdata[0] = 16'h7777;
    tick(); addr[0] = 16'h0008; wdata[0] = 16'h8888;
    tick(); addr[0] = 16'h0009; wdata[0] = 16'h9999;
    check("t5_pulse_c2", 32'(ws[0]), 32'h1);
    tick(); wr_s[0] = 1'b0; rst = 1'b1;
    q0.delete();
    tick(); rst = 1'b0;
    check("t5_wa_wr_s", 32'(ws[0]), 32'h0);
    check("t5_wa_addr", 32'(waddr[0]), 32'h0);
    check("t5_wa_data", 32'(wdat[0]), 32'h0);
    check("t5_pending", 32'(pend[0]), 32'h0);
    check("t5_rdata", 32'(rdata[0]), 32'h0);
    ticks(10);
    check("t5_no_pulses", 32'(q0.size()), 32'h0);
    check("t5_pending_late", 32'(pend[0]), 32'h0);
    rd_s[0] = 1'b1; addr[0] = 16'h0007;
    tick(); rd_s[0] = 1'b0;
    check("t5_reg_cleared", 32'(rdata[0]), 32'h0);

    // 2: depth 2, gap 3, six back-to-back writes
    exp_cyc = '{2, 6, 10, 14};
    exp_idx = '{0, 1, 2, 5};
    for (int i = 0; i < 6; i++) begin
      tick(); wr_s[1] = 1'b1; addr[1] = 16'(i); wdata[1] = 16'hB000 + 16'(i);
      if (i == 0) t0 = cyc;
    end
    tick(); wr_s[1] = 1'b0;
    ticks(20);
    check("t2_pulse_count", 32'(q1.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      item = (q1.size() > 0) ? q1.pop_front() : '1;
      check($sformatf("t2_cyc%0d", j), item[63:32] - 32'(t0), 32'(exp_cyc[j]));
      check($sformatf("t2_addr%0d", j), 32'(item[31:16]), 32'(exp_idx[j]));
      check($sformatf("t2_data%0d", j), 32'(item[15:0]), 32'h0000B000 + 32'(exp_idx[j]));
    end
    check("t2_ovf", 32'(ovf[1]), 32'd2);
    check("t2_pending_clear", 32'(pend[1]), 32'h0);

    // 6: 300 writes against depth 4, gap 15; pops fall on cycles 1+16k
    occ = 0;
    for (int c = 0; c < 300; c++) begin
      tick(); wr_s[2] = 1'b1; addr[2] = 16'(c & 15); wdata[2] = 16'(c);
      if (c == 0) t0 = cyc;
      pop_now = ((c % 16) == 1) && (occ > 0);
      if ((occ < 4) || pop_now) begin
        expq.push_back({16'(c & 15), 16'(c)});
        occ++;
      end
      if (pop_now) occ--;
    end
    tick(); wr_s[2] = 1'b0;
    ticks(100);
    check("t6_ovf_sat", 32'(ovf[2]), 32'hFF);
    check("t6_pulse_count", 32'(q2.size()), 32'(expq.size()));
    for (int j = 0; j < expq.size(); j++) begin
      e    = expq[j];
      item = (q2.size() > 0) ? q2.pop_front() : '1;
      check($sformatf("t6_cyc%0d", j), item[63:32] - 32'(t0), 32'(2 + 16 * j));
      check($sformatf("t6_rec%0d", j), item[31:0], e);
    end
    check("t6_pending_clear", 32'(pend[2]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
